// File: rtl/async_fifo_pkg.sv
// Shared Gray/binary helpers for the async FIFO pointer blocks (read and write side).
// The functions work on 32-bit vectors; callers zero-extend narrower pointers and
// truncate the result, which is exact for both conversions.
package async_fifo_pkg;

   localparam int GRAY_MAX_W = 32;

   // Binary to reflected Gray code.
   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Reflected Gray code to binary: each bit is the XOR of itself and all higher Gray bits.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/rptr_level_gray2bin.sv
// Combinational Gray-to-binary decoder of parametrised width (XOR prefix from the MSB down).
module rptr_level_gray2bin #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   // Binary bit i is the parity of Gray bits W-1 down to i.
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin_o[i] = ^gray_i[W-1:i];
   end

endmodule

// File: rtl/rptr_level.sv
// Read-domain pointer and status block of the async FIFO: binary/Gray read pointer,
// empty and almost-empty flags, fill level, read-accept strobe and sticky underflow.
// rq2_wptr is already synchronised into rclk; there is no CDC logic in here.
module rptr_level
   import async_fifo_pkg::*;
#(
   parameter int ADDRSIZE = 4
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic                rinc,
   input  logic [ADDRSIZE:0]   rq2_wptr,
   input  logic [ADDRSIZE:0]   arempty_thresh,
   input  logic                rerr_clr,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic                arempty,
   output logic [ADDRSIZE:0]   rlevel,
   output logic                rack,
   output logic                runderflow
);

   localparam int PW = ADDRSIZE + 1;

   logic [PW-1:0] rbin_q,    rbin_d;
   logic [PW-1:0] rptr_q,    rptr_d;
   logic [PW-1:0] rlevel_q,  rlevel_d;
   logic          rempty_q,  rempty_d;
   logic          arempty_q, arempty_d;
   logic          rack_q,    rack_d;
   logic          ruflow_q,  ruflow_d;

   logic [PW-1:0] wbin;
   logic          racc;

   rptr_level_gray2bin #(.W(PW)) u_wptr_dec (
      .gray_i (rq2_wptr),
      .bin_o  (wbin)
   );

   // Next pointer, level and flag values; the level is computed against the post-read pointer.
   always_comb begin
      racc      = rinc & ~rempty_q;
      rbin_d    = rbin_q + {{(PW-1){1'b0}}, racc};
      rptr_d    = PW'(bin2gray(32'(rbin_d)));
      rlevel_d  = wbin - rbin_d;
      // Gray equality including the wrap bit; identical to rlevel_d == 0.
      rempty_d  = (rptr_d == rq2_wptr);
      arempty_d = (rlevel_d <= arempty_thresh);
      rack_d    = racc;
      // A read against an empty FIFO wins over a simultaneous clear.
      if (rinc & rempty_q) begin
         ruflow_d = 1'b1;
      end else if (rerr_clr) begin
         ruflow_d = 1'b0;
      end else begin
         ruflow_d = ruflow_q;
      end
   end

   // Single register stage for all pointer and status state, synchronous reset.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin_q    <= '0;
         rptr_q    <= '0;
         rlevel_q  <= '0;
         rempty_q  <= 1'b1;
         arempty_q <= 1'b1;
         rack_q    <= 1'b0;
         ruflow_q  <= 1'b0;
      end else begin
         rbin_q    <= rbin_d;
         rptr_q    <= rptr_d;
         rlevel_q  <= rlevel_d;
         rempty_q  <= rempty_d;
         arempty_q <= arempty_d;
         rack_q    <= rack_d;
         ruflow_q  <= ruflow_d;
      end
   end

   assign raddr      = rbin_q[ADDRSIZE-1:0];
   assign rptr       = rptr_q;
   assign rempty     = rempty_q;
   assign arempty    = arempty_q;
   assign rlevel     = rlevel_q;
   assign rack       = rack_q;
   assign runderflow = ruflow_q;

endmodule

// File: tb/tb_rptr_level.sv
// Bench for rptr_level: directed scenarios plus randomised read/write streams,
// all outputs compared each cycle against a counter-based FIFO occupancy model.
module tb_rptr_level;

   localparam int AS    = 4;
   localparam int PW    = AS + 1;
   localparam int DEPTH = 16;

   logic          rclk = 1'b0;
   logic          rrst = 1'b1;
   logic          rinc = 1'b0;
   logic          rerr_clr = 1'b0;
   logic [PW-1:0] rq2_wptr = '0;
   logic [PW-1:0] arempty_thresh = '0;
   logic [AS-1:0] raddr;
   logic [PW-1:0] rptr;
   logic          rempty;
   logic          arempty;
   logic [PW-1:0] rlevel;
   logic          rack;
   logic          runderflow;

   rptr_level #(.ADDRSIZE(AS)) dut (
      .rclk           (rclk),
      .rrst           (rrst),
      .rinc           (rinc),
      .rq2_wptr       (rq2_wptr),
      .arempty_thresh (arempty_thresh),
      .rerr_clr       (rerr_clr),
      .raddr          (raddr),
      .rptr           (rptr),
      .rempty         (rempty),
      .arempty        (arempty),
      .rlevel         (rlevel),
      .rack           (rack),
      .runderflow     (runderflow)
   );

   always #5 rclk = ~rclk;

   int total = 0;
   int bad   = 0;

   // Reference model: total reads and writes as plain integers since reset.
   int m_rd    = 0;
   int m_wr    = 0;
   int m_level = 0;
   bit m_empty  = 1'b1;
   bit m_aempty = 1'b1;
   bit m_rack   = 1'b0;
   bit m_uf     = 1'b0;

   int rack_cnt  = 0;
   int prev_rptr = 0;
   int wrap_seen = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int gray(input int b);
      return b ^ (b >> 1);
   endfunction

   // Apply one cycle of inputs, advance the model, then compare every output.
   task automatic step(input bit inc, input int wr, input int thr, input bit clr, input bit rst);
      bit acc;
      rinc           = inc;
      rerr_clr       = clr;
      rrst           = rst;
      m_wr           = wr;
      rq2_wptr       = PW'(gray(wr % 32));
      arempty_thresh = PW'(thr);
      @(posedge rclk);
      if (rst) begin
         m_rd = 0; m_level = 0; m_empty = 1'b1; m_aempty = 1'b1;
         m_rack = 1'b0; m_uf = 1'b0;
      end else begin
         acc  = inc && !m_empty;
         m_uf = (inc && m_empty) ? 1'b1 : (clr ? 1'b0 : m_uf);
         if (acc) m_rd++;
         m_rack   = acc;
         m_level  = m_wr - m_rd;
         m_empty  = (m_level == 0);
         m_aempty = (m_level <= thr);
      end
      #1;
      chk("rptr",       int'(rptr),       gray(m_rd % 32));
      chk("raddr",      int'(raddr),      m_rd % DEPTH);
      chk("rempty",     int'(rempty),     int'(m_empty));
      chk("arempty",    int'(arempty),    int'(m_aempty));
      chk("rlevel",     int'(rlevel),     m_level);
      chk("rack",       int'(rack),       int'(m_rack));
      chk("runderflow", int'(runderflow), int'(m_uf));
      if (rack) rack_cnt++;
      if (!rst && prev_rptr == gray(31) && int'(rptr) == 0) wrap_seen++;
      prev_rptr = int'(rptr);
   endtask

   initial begin
      int wr;
      int thr;
      bit inc;

      // Reset held two cycles with a read request pending.
      step(1, 0, 2, 0, 1);
      step(1, 0, 2, 0, 1);
      chk("rst_rptr",   int'(rptr),       0);
      chk("rst_rempty", int'(rempty),     1);
      chk("rst_arempt", int'(arempty),    1);
      chk("rst_rlevel", int'(rlevel),     0);
      chk("rst_rack",   int'(rack),       0);
      chk("rst_uflow",  int'(runderflow), 0);

      // Five entries arrive, threshold 2, then drain them.
      step(0, 5, 2, 0, 0);
      chk("fill_level",  int'(rlevel),  5);
      chk("fill_arempt", int'(arempty), 0);
      rack_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1, 5, 2, 0, 0);
         chk("drain_level",  int'(rlevel),  4 - i);
         chk("drain_arempt", int'(arempty), int'((4 - i) <= 2));
      end
      chk("drain_empty", int'(rempty), 1);
      step(0, 5, 2, 0, 0);
      chk("rack_pulses", rack_cnt, 5);

      // Underflow: set, hold, clear, set-beats-clear, clear.
      step(1, 5, 2, 0, 0);
      chk("uf_set",  int'(runderflow), 1);
      chk("uf_rptr", int'(rptr),       gray(5));
      chk("uf_rack", int'(rack),       0);
      step(0, 5, 2, 0, 0);
      chk("uf_hold", int'(runderflow), 1);
      step(0, 5, 2, 1, 0);
      chk("uf_clr", int'(runderflow), 0);
      step(1, 5, 2, 1, 0);
      chk("uf_prio", int'(runderflow), 1);
      step(0, 5, 2, 1, 0);
      chk("uf_clr2", int'(runderflow), 0);

      // Full-depth level with differing wrap bits.
      step(0, 0, 2, 0, 1);
      step(0, 3, 2, 0, 0);
      repeat (3) step(1, 3, 2, 0, 0);
      step(0, 19, 2, 0, 0);
      chk("full_lvl_a",   int'(rlevel), 16);
      chk("full_empty_a", int'(rempty), 0);
      repeat (16) step(1, 19, 2, 0, 0);
      step(0, 20, 2, 0, 0);
      step(1, 20, 2, 0, 0);
      step(0, 36, 2, 0, 0);
      chk("full_lvl_b",   int'(rlevel), 16);
      chk("full_empty_b", int'(rempty), 0);

      // Random streams: threshold 0, threshold 17, then random thresholds.
      step(0, 0, 0, 0, 1);
      for (int ph = 0; ph < 3; ph++) begin
         for (int c = 0; c < 300; c++) begin
            thr = (ph == 0) ? 0 : (ph == 1) ? 17 : int'($urandom_range(0, 16));
            wr  = m_wr;
            if ((m_wr - m_rd) < DEPTH && ($urandom % 3) != 0) wr++;
            inc = ($urandom % 2) == 0;
            step(inc, wr, thr, ($urandom % 8) == 0, 0);
            if (ph == 0) chk("th0_track", int'(arempty), int'(rempty));
            if (ph == 1) chk("th17_one",  int'(arempty), 1);
         end
      end
      chk("wrap_seen", int'(wrap_seen > 0), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
